// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and ALU-operation encodings for the multicycle MIPS control path.
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BEQEX   = 4'd10,
    BNEEX   = 4'd11,
    JEX     = 4'd12
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || is_imm_op(op);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_outdec.sv
// mc_outdec: combinational decode of FSM state, opcode and memready into the datapath control word.
`default_nettype none

module mc_outdec
  import mips_ctrl_pkg::*;
(
  input  statetype    i_state,
  input  logic [5:0]  i_op,
  input  logic        i_memready,
  output logic        o_memwrite,
  output logic        o_irwrite,
  output logic        o_regwrite,
  output logic        o_pcwrite,
  output logic        o_iord,
  output logic        o_regdst,
  output logic        o_memtoreg,
  output logic        o_alusrca,
  output logic        o_zeroext,
  output logic [1:0]  o_alusrcb,
  output logic [1:0]  o_pcsrc,
  output logic        o_branch,
  output logic        o_branchne,
  output logic [2:0]  o_aluop,
  output logic        o_illegal
);

  always_comb begin
    o_memwrite = 1'b0;
    o_irwrite  = 1'b0;
    o_regwrite = 1'b0;
    o_pcwrite  = 1'b0;
    o_iord     = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_alusrca  = 1'b0;
    o_zeroext  = 1'b0;
    o_alusrcb  = 2'b00;
    o_pcsrc    = 2'b00;
    o_branch   = 1'b0;
    o_branchne = 1'b0;
    o_aluop    = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_state)
      FETCH: begin
        // IR and PC load only on the cycle memory actually returns the word
        o_alusrcb = 2'b01;
        o_irwrite = i_memready;
        o_pcwrite = i_memready;
      end
      DECODE: begin
        o_alusrcb = 2'b11;
        o_illegal = !is_known_op(i_op);
      end
      MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
      end
      MEMRD: o_iord = 1'b1;
      MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      RTYPEEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALU_FUNCT;
      end
      RTYPEWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      IMMEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        case (i_op)
          OP_SLTI: o_aluop = ALU_SLT;
          OP_ANDI: begin
            o_aluop   = ALU_AND;
            o_zeroext = 1'b1;
          end
          OP_ORI: begin
            o_aluop   = ALU_OR;
            o_zeroext = 1'b1;
          end
          default: o_aluop = ALU_ADD;
        endcase
      end
      IMMWB: o_regwrite = 1'b1;
      BEQEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALU_SUB;
        o_pcsrc   = 2'b01;
        o_branch  = 1'b1;
      end
      BNEEX: begin
        o_alusrca  = 1'b1;
        o_aluop    = ALU_SUB;
        o_pcsrc    = 2'b01;
        o_branchne = 1'b1;
      end
      JEX: begin
        o_pcsrc   = 2'b10;
        o_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle MIPS main control FSM; holds the state register and next-state logic.
`default_nettype none

module mc_maindec
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        memready,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        pcwrite,
  output logic        iord,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic        zeroext,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic        branch,
  output logic        branchne,
  output logic [2:0]  aluop,
  output logic        illegal
);

  statetype r_state;
  statetype w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = memready ? DECODE : FETCH;
      DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) w_next = MEMADR;
        else if (op == OP_RTYPE)            w_next = RTYPEEX;
        else if (op == OP_BEQ)              w_next = BEQEX;
        else if (op == OP_BNE)              w_next = BNEEX;
        else if (is_imm_op(op))             w_next = IMMEX;
        else if (op == OP_J)                w_next = JEX;
        else                                w_next = FETCH;
      end
      MEMADR:  w_next = (op == OP_SW) ? MEMWR : ((op == OP_LW) ? MEMRD : FETCH);
      MEMRD:   w_next = memready ? MEMWB : MEMRD;
      MEMWR:   w_next = memready ? FETCH : MEMWR;
      RTYPEEX: w_next = RTYPEWB;
      IMMEX:   w_next = IMMWB;
      // Writebacks, branches, jumps and unused encodings all return to FETCH
      default: w_next = FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .i_state    (r_state),
    .i_op       (op),
    .i_memready (memready),
    .o_memwrite (memwrite),
    .o_irwrite  (irwrite),
    .o_regwrite (regwrite),
    .o_pcwrite  (pcwrite),
    .o_iord     (iord),
    .o_regdst   (regdst),
    .o_memtoreg (memtoreg),
    .o_alusrca  (alusrca),
    .o_zeroext  (zeroext),
    .o_alusrcb  (alusrcb),
    .o_pcsrc    (pcsrc),
    .o_branch   (branch),
    .o_branchne (branchne),
    .o_aluop    (aluop),
    .o_illegal  (illegal)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: scoreboard bench; stimulus queues the expected control word per cycle, a monitor compares.
`default_nettype none

module tb_mc_maindec;

  typedef enum int {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
                    S_RTYPEWB, S_IMMEX, S_IMMWB, S_BEQEX, S_BNEEX, S_JEX} st_t;

  typedef struct {
    logic [18:0] w;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        memready;
  logic        memwrite, irwrite, regwrite, pcwrite, iord, regdst, memtoreg;
  logic        alusrca, zeroext, branch, branchne, illegal;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  aluop;
  logic [18:0] w_got;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  mc_maindec dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .pcwrite(pcwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .zeroext(zeroext), .alusrcb(alusrcb), .pcsrc(pcsrc), .branch(branch),
    .branchne(branchne), .aluop(aluop), .illegal(illegal)
  );

  assign w_got = {memwrite, irwrite, regwrite, pcwrite, iord, regdst, memtoreg, alusrca,
                  zeroext, alusrcb, pcsrc, branch, branchne, aluop, illegal};

  always #5 clk = ~clk;

  // Expected control word written directly from the state table
  function automatic logic [18:0] exp_w(input st_t st, input logic [5:0] o, input logic mr);
    logic mw = 0, ir = 0, rw = 0, pw = 0, io = 0, rd = 0, m2r = 0, sa = 0, ze = 0;
    logic br = 0, bn = 0, il = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ao = 3'b000;
    case (st)
      S_FETCH:   begin sb = 2'b01; ir = mr; pw = mr; end
      S_DECODE:  begin
        sb = 2'b11;
        il = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                         6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b000010});
      end
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin m2r = 1; rw = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_RTYPEEX: begin sa = 1; ao = 3'b010; end
      S_RTYPEWB: begin rd = 1; rw = 1; end
      S_IMMEX:   begin
        sa = 1; sb = 2'b10;
        if (o == 6'b001010)      ao = 3'b101;
        else if (o == 6'b001100) begin ao = 3'b100; ze = 1; end
        else if (o == 6'b001101) begin ao = 3'b011; ze = 1; end
      end
      S_IMMWB:   rw = 1;
      S_BEQEX:   begin sa = 1; ao = 3'b001; ps = 2'b01; br = 1; end
      S_BNEEX:   begin sa = 1; ao = 3'b001; ps = 2'b01; bn = 1; end
      S_JEX:     begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {mw, ir, rw, pw, io, rd, m2r, sa, ze, sb, ps, br, bn, ao, il};
  endfunction

  task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  task automatic step(input logic [5:0] opv, input logic mr, input st_t st, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    op       = opv;
    memready = mr;
    e.w  = exp_w(st, opv, mr);
    e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, w_got, e.w);
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e;
    reset = 1'b0; op = 6'b000000; memready = 1'b1;
    step(6'b000000, 1, S_FETCH, "reset fetch 0");
    step(6'b000000, 1, S_FETCH, "reset fetch 1");

    // Release reset during a FETCH cycle; lw with two MEMRD stalls
    @(posedge clk);
    #1;
    reset = 1'b1; op = 6'b100011; memready = 1'b1;
    e.w = exp_w(S_FETCH, 6'b100011, 1'b1); e.nm = "lw fetch";
    q.push_back(e);
    step(6'b100011, 1, S_DECODE, "lw decode");
    step(6'b100011, 1, S_MEMADR, "lw memadr");
    step(6'b100011, 0, S_MEMRD,  "lw memrd stall0");
    step(6'b100011, 0, S_MEMRD,  "lw memrd stall1");
    step(6'b100011, 1, S_MEMRD,  "lw memrd done");
    step(6'b100011, 1, S_MEMWB,  "lw memwb");

    foreach (q[i]) ;
    step(6'b001101, 1, S_FETCH,  "ori fetch");
    step(6'b001101, 1, S_DECODE, "ori decode");
    step(6'b001101, 1, S_IMMEX,  "ori immex");
    step(6'b001101, 1, S_IMMWB,  "ori immwb");

    step(6'b000101, 1, S_FETCH,  "bne fetch");
    step(6'b000101, 1, S_DECODE, "bne decode");
    step(6'b000101, 1, S_BNEEX,  "bne bneex");

    step(6'b111111, 1, S_FETCH,  "illegal fetch");
    step(6'b111111, 1, S_DECODE, "illegal decode");

    step(6'b000100, 1, S_FETCH,  "beq fetch");
    step(6'b000100, 1, S_DECODE, "beq decode");
    step(6'b000100, 1, S_BEQEX,  "beq beqex");

    step(6'b000000, 1, S_FETCH,   "rtype fetch");
    step(6'b000000, 1, S_DECODE,  "rtype decode");
    step(6'b000000, 1, S_RTYPEEX, "rtype ex");
    step(6'b000000, 1, S_RTYPEWB, "rtype wb");

    step(6'b001010, 1, S_FETCH,  "slti fetch");
    step(6'b001010, 1, S_DECODE, "slti decode");
    step(6'b001010, 1, S_IMMEX,  "slti immex");
    step(6'b001010, 1, S_IMMWB,  "slti immwb");

    step(6'b001100, 1, S_FETCH,  "andi fetch");
    step(6'b001100, 1, S_DECODE, "andi decode");
    step(6'b001100, 1, S_IMMEX,  "andi immex");
    step(6'b001100, 1, S_IMMWB,  "andi immwb");

    step(6'b001000, 1, S_FETCH,  "addi fetch");
    step(6'b001000, 1, S_DECODE, "addi decode");
    step(6'b001000, 1, S_IMMEX,  "addi immex");
    step(6'b001000, 1, S_IMMWB,  "addi immwb");

    // sw with a FETCH stall, completing normally
    step(6'b101011, 0, S_FETCH,  "sw fetch stall");
    step(6'b101011, 1, S_FETCH,  "sw fetch");
    step(6'b101011, 1, S_DECODE, "sw decode");
    step(6'b101011, 1, S_MEMADR, "sw memadr");
    step(6'b101011, 1, S_MEMWR,  "sw memwr");

    // sw held in MEMWR, then aborted by asynchronous reset
    step(6'b101011, 1, S_FETCH,  "sw2 fetch");
    step(6'b101011, 1, S_DECODE, "sw2 decode");
    step(6'b101011, 1, S_MEMADR, "sw2 memadr");
    step(6'b101011, 0, S_MEMWR,  "sw2 memwr hold");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async memwrite drop", {18'b0, memwrite}, 19'b0);
    chk("async state fetch", w_got, exp_w(S_FETCH, 6'b101011, 1'b0));
    step(6'b101011, 1, S_FETCH, "reset held fetch");

    @(posedge clk);
    #1;
    reset = 1'b1; op = 6'b000010; memready = 1'b1;
    e.w = exp_w(S_FETCH, 6'b000010, 1'b1); e.nm = "j fetch";
    q.push_back(e);
    step(6'b000010, 1, S_DECODE, "j decode");
    step(6'b000010, 1, S_JEX,    "j jex");
    step(6'b000000, 1, S_FETCH,  "final fetch");

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 19'(q.size()), 19'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_maindec.md
# mc_maindec

Main control state machine for the multicycle MIPS core. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and multiplexer selects. It also produces the 3-bit `aluop` consumed directly by the ALU decoder, which turns `aluop` plus `funct` into `alucontrol`. It sits between the instruction register (opcode source) and the ALU decoder/datapath.

## Interface
- No parameters; encodings are fixed by the package.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; `0` forces state FETCH immediately.
- `op` in 6: `instr[31:26]` from the instruction register.
- `memready` in 1: memory completes the current access this cycle.
- `memwrite`, `irwrite`, `regwrite`, `pcwrite` out 1: write enables.
- `iord`, `regdst`, `memtoreg`, `alusrca`, `zeroext` out 1: mux selects.
- `alusrcb` out 2: `00` reg B, `01` const 4, `10` imm, `11` imm<<2.
- `pcsrc` out 2: `00` ALU result, `01` ALUOut, `10` jump target.
- `branch`, `branchne` out 1: qualified with `zero` in the datapath as `pcen = pcwrite | branch&zero | branchne&~zero`.
- `aluop` out 3: to the ALU decoder.
  - `000` add, `001` sub, `010` use `funct`, `011` or, `100` and, `101` slt.
- `illegal` out 1: one-cycle flag in DECODE when the opcode is not recognised.

## Operation
- Recognised opcodes:
  - R `000000`, lw `100011`, sw `101011`
  - beq `000100`, bne `000101`
  - addi `001000`, slti `001010`, andi `001100`, ori `001101`
  - j `000010`
- Outputs not listed for a state are `0`.
- FETCH:
  - `iord=0`, `alusrca=0`, `alusrcb=01`, `aluop=000`, `pcsrc=00`.
  - `irwrite=pcwrite=memready` (Mealy).
  - Stay while `memready=0`; go to DECODE when it is `1`.
- DECODE: `alusrca=0`, `alusrcb=11`, `aluop=000` (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR; R -> RTYPEEX; beq -> BEQEX; bne -> BNEEX.
  - addi/andi/ori/slti -> IMMEX; j -> JEX.
  - Unknown -> FETCH with `illegal=1`.
- MEMADR: `alusrca=1`, `alusrcb=10`, `aluop=000`. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: `iord=1`. Hold until `memready`, then -> MEMWB.
- MEMWB: `regdst=0`, `memtoreg=1`, `regwrite=1`. Next: FETCH.
- MEMWR: `iord=1`, `memwrite=1`. Hold until `memready`, then -> FETCH. `memwrite` stays high while held.
- RTYPEEX: `alusrca=1`, `alusrcb=00`, `aluop=010`. Next: RTYPEWB.
- RTYPEWB: `regdst=1`, `memtoreg=0`, `regwrite=1`. Next: FETCH.
- IMMEX: `alusrca=1`, `alusrcb=10`, ALU operation and extension per opcode:
  - addi: `aluop=000`, `zeroext=0`.
  - slti: `aluop=101`, `zeroext=0`.
  - andi: `aluop=100`, `zeroext=1`.
  - ori: `aluop=011`, `zeroext=1`.
  - Next: IMMWB.
- IMMWB: `regdst=0`, `memtoreg=0`, `regwrite=1`. Next: FETCH.
- BEQEX / BNEEX: `alusrca=1`, `alusrcb=00`, `aluop=001`, `pcsrc=01`. `branch=1` (BEQEX) or `branchne=1` (BNEEX). Next: FETCH.
- JEX: `pcsrc=10`, `pcwrite=1`. Next: FETCH.
- `op` is sampled in DECODE, MEMADR and IMMEX. The IR is stable there because `irwrite` is only asserted in FETCH.

## Timing
- Reset:
  - State is FETCH; outputs are FETCH values.
  - `irwrite`/`pcwrite` follow `memready`; the datapath is also in reset, so writes are harmless.
  - All other outputs are `0`, `illegal=0`.
  - Deassertion is taken on the next `clk` edge.
- Reset asserted mid-instruction aborts the instruction. No partial register or memory write occurs after the asynchronous assertion.
- Cycle counts with `memready` always `1`:
  - lw 5; sw 4; R-type 4; immediate 4; beq/bne 3; j 3; illegal 2.
  - Each cycle of `memready=0` in FETCH, MEMRD or MEMWR adds one cycle.
- Outputs are combinational from state (plus `op` and `memready` where noted). No output register, so there is zero latency from state to control.
- Unreachable state encodings recover to FETCH on the next edge.

## Structure
- Package `mips_ctrl_pkg`:
  - `statetype` enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, IMMEX, IMMWB, BEQEX, BNEEX, JEX.
  - Opcode localparams.
  - `aluop` localparams (`ALU_ADD`, `ALU_SUB`, `ALU_FUNCT`, `ALU_OR`, `ALU_AND`, `ALU_SLT`); the ALU decoder shares these.
- One sub-module, `mc_outdec`: combinational state/op/memready -> control word. `mc_maindec` keeps only the state register and next-state logic.

## Test plan
- Reset held low with `memready=1`: state is FETCH, `irwrite=1`, `pcwrite=1`, `alusrcb=01`, `aluop=000`. After release: DECODE at the next edge.
- `op=100011` (lw), `memready` low for 2 cycles in MEMRD: sequence is FETCH, DECODE, MEMADR, MEMRD×3, MEMWB with `regwrite=1`, `memtoreg=1`; total 7 cycles.
- `op=001101` (ori): IMMEX shows `aluop=011`, `zeroext=1`, `alusrcb=10`. IMMWB shows `regwrite=1`, `regdst=0`.
- `op=000101` (bne): BNEEX shows `branchne=1`, `branch=0`, `pcsrc=01`, `aluop=001`; returns to FETCH after 3 cycles.
- `op=111111`: `illegal=1` for exactly one cycle in DECODE, then FETCH. No write enables are asserted.
- Reset pulled low asynchronously during MEMWR: `memwrite` drops before the next edge and the state reads FETCH.
